// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART framebuffer loader.
package uart_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StSync,
    StRed,
    StGreen,
    StBlue
  } loader_state_t;

  localparam logic [7:0] UART_SYNC0 = 8'hAA;
  localparam logic [7:0] UART_SYNC1 = 8'h55;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/uart_timeout_timer.sv
// Idle-cycle counter; pulses expired_o for one cycle when the count reaches TIMEOUT_CYCLES-1.
module uart_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear has priority, so a byte arriving on the expiry cycle suppresses the pulse.
  always_comb begin
    cnt_d     = cnt_q;
    expired_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q == CntLast) begin
        expired_o = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Hunts for a two-byte sync header, packs following bytes into RGB pixels and writes them
// to the framebuffer at an auto-incrementing address; aborts on inter-byte timeout.
module uart_frame_loader
  import uart_pkg::*;
#(
  parameter int unsigned PIXELS         = 76800,
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC0          = UART_SYNC0,
  parameter logic [7:0]  SYNC1          = UART_SYNC1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(PIXELS - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  pixel_t            wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_err_q, timeout_err_d;

  logic              expired;

  uart_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (rx_ready || (state_q == StHunt)),
    .enable_i (state_q != StHunt),
    .expired_o(expired)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    r_d           = r_q;
    g_d           = g_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;

    if (rx_ready) begin
      unique case (state_q)
        StHunt: begin
          if (rx_data == SYNC0) state_d = StSync;
        end
        StSync: begin
          if (rx_data == SYNC1) begin
            state_d = StRed;
            addr_d  = '0;
          end else if (rx_data != SYNC0) begin
            state_d = StHunt;
          end
        end
        StRed: begin
          r_d     = rx_data;
          state_d = StGreen;
        end
        StGreen: begin
          g_d     = rx_data;
          state_d = StBlue;
        end
        StBlue: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pixel_t'{r: r_q, g: g_q, b: rx_data};
          if (addr_q == AddrLast) begin
            frame_done_d = 1'b1;
            state_d      = StHunt;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRed;
          end
        end
        default: state_d = StHunt;
      endcase
    end else if (expired) begin
      // Partial pixel is dropped; already-written pixels stay in memory.
      timeout_err_d = 1'b1;
      state_d       = StHunt;
    end

    busy_d = (state_d != StHunt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StHunt;
      addr_q        <= '0;
      r_q           <= '0;
      g_q           <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      r_q           <= r_d;
      g_q           <= g_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

endmodule
